// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU stage, the result FIFO and its downstream consumer.
// The slave modport is the FIFO's view; the master modport is the surrounding logic's view.
interface alu_result_fifo_if #(
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [63:0]   in_result;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_op;
    logic [63:0]   out_result;
    logic          out_zero;
    logic          out_hi_nz;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    modport slave (
        input  in_valid, in_op, in_result, out_ready,
        output in_ready, out_valid, out_op, out_result, out_zero, out_hi_nz,
               count, full, empty
    );

    modport master (
        output in_valid, in_op, in_result, out_ready,
        input  in_ready, out_valid, out_op, out_result, out_zero, out_hi_nz,
               count, full, empty
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO that buffers ALU results together with zero and
// upper-word-nonzero flags computed on entry.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_fifo_if.slave    bus
);
    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] result;
        logic        zero;
        logic        hi_nz;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full, empty, push, pop;

    // Flow control looks only at registered occupancy, so out_ready never reaches in_ready.
    always_comb begin
        full            = (count_q == (AW + 1)'(DEPTH));
        empty           = (count_q == '0);
        push            = bus.in_valid & ~full;
        pop             = bus.out_ready & ~empty;

        wr_entry.op     = bus.in_op;
        wr_entry.result = bus.in_result;
        wr_entry.zero   = (bus.in_result == 64'd0);
        wr_entry.hi_nz  = |bus.in_result[63:32];

        wr_ptr_d        = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d        = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d         = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; head fields are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign head           = mem[rd_ptr_q];

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ~empty;
    assign bus.out_op     = head.op;
    assign bus.out_result = head.result;
    assign bus.out_zero   = head.zero;
    assign bus.out_hi_nz  = head.hi_nz;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: hand-computed expectations checked with
// immediate assertions, sampled 1ns after each rising clock edge.
module tb_alu_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    alu_result_fifo_if #(.AW(2)) f ();

    alu_result_fifo #(.DEPTH(4), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (f)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [63:0] result, input logic oready);
        f.in_valid  = valid;
        f.in_op     = op;
        f.in_result = result;
        f.out_ready = oready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " count"},     64'(f.count),     64'd0);
        checkOutput({tag, " empty"},     64'(f.empty),     64'd1);
        checkOutput({tag, " full"},      64'(f.full),      64'd0);
        checkOutput({tag, " in_ready"},  64'(f.in_ready),  64'd1);
        checkOutput({tag, " out_valid"}, 64'(f.out_valid), 64'd0);
    endtask

    task automatic checkHead(input string tag, input logic [2:0] op, input logic [63:0] result,
                             input logic zero, input logic hi_nz);
        checkOutput({tag, " out_valid"}, 64'(f.out_valid), 64'd1);
        checkOutput({tag, " out_op"},    64'(f.out_op),    64'(op));
        checkOutput({tag, " out_result"}, f.out_result,    result);
        checkOutput({tag, " out_zero"},  64'(f.out_zero),  64'(zero));
        checkOutput({tag, " out_hi_nz"}, 64'(f.out_hi_nz), 64'(hi_nz));
    endtask

    initial begin
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkIdle("reset");
        rst = 1'b0;
        tick();
        checkIdle("idle");

        // Single push, visible the cycle after the push edge
        applyStimulus(1'b1, 3'b000, 64'h0000_0000_0000_0005, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkHead("push5", 3'b000, 64'd5, 1'b0, 1'b0);
        checkOutput("push5 count", 64'(f.count), 64'd1);
        f.out_ready = 1'b1;
        tick();
        f.out_ready = 1'b0;
        checkOutput("pop5 empty", 64'(f.empty), 64'd1);

        // Flag computation
        applyStimulus(1'b1, 3'b010, 64'h0000_0001_0000_0000, 1'b0);
        tick();
        applyStimulus(1'b1, 3'b001, 64'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkHead("mul", 3'b010, 64'h0000_0001_0000_0000, 1'b0, 1'b1);
        checkOutput("mul count", 64'(f.count), 64'd2);
        f.out_ready = 1'b1;
        tick();
        f.out_ready = 1'b0;
        checkHead("zero", 3'b001, 64'd0, 1'b1, 1'b0);
        checkOutput("zero count", 64'(f.count), 64'd1);
        f.out_ready = 1'b1;
        tick();
        f.out_ready = 1'b0;
        checkIdle("drain1");

        // Fill to full, reject a fifth push, drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'(i + 3), 64'(8'h11 * (i + 1)), 1'b0);
            tick();
        end
        checkOutput("fill full", 64'(f.full), 64'd1);
        checkOutput("fill in_ready", 64'(f.in_ready), 64'd0);
        checkOutput("fill count", 64'(f.count), 64'd4);
        applyStimulus(1'b1, 3'd7, 64'h55, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkOutput("ignored count", 64'(f.count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkHead("drain", 3'(i + 3), 64'(8'h11 * (i + 1)), 1'b0, 1'b0);
            f.out_ready = 1'b1;
            tick();
            f.out_ready = 1'b0;
        end
        checkIdle("drain2");

        // Steady state at count=2 with simultaneous push/pop; pointers lap several times
        applyStimulus(1'b1, 3'd1, 64'd100, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd1, 64'd101, 1'b0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 3'd2, 64'(i), 1'b1);
            checkOutput("stream head", f.out_result,
                        (i == 1) ? 64'd100 : (i == 2) ? 64'd101 : 64'(i - 2));
            tick();
            checkOutput("stream count", 64'(f.count), 64'd2);
        end
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b1);
        checkOutput("stream tail9", f.out_result, 64'd9);
        tick();
        checkOutput("stream tail10", f.out_result, 64'd10);
        tick();
        f.out_ready = 1'b0;
        checkIdle("drain3");

        // Full with push and pop together: only the pop happens, push lands next cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'd6, 64'(8'hA0 + i), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 3'd5, 64'hA4, 1'b1);
        checkOutput("fullpp in_ready", 64'(f.in_ready), 64'd0);
        tick();
        checkOutput("fullpp count", 64'(f.count), 64'd3);
        checkOutput("fullpp in_ready after", 64'(f.in_ready), 64'd1);
        checkOutput("fullpp head", f.out_result, 64'hA1);
        f.out_ready = 1'b0;
        tick();
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkOutput("fullpp refill", 64'(f.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            checkHead("fullpp drain", (i == 4) ? 3'd5 : 3'd6, 64'(8'hA0 + i), 1'b0, 1'b0);
            f.out_ready = 1'b1;
            tick();
            f.out_ready = 1'b0;
        end
        checkIdle("drain4");

        // Asynchronous reset mid-stream, observed between clock edges
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'd0, 64'(i + 1), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkOutput("pre-reset count", 64'(f.count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async reset");
        tick();
        rst = 1'b0;
        tick();
        checkIdle("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
